data_memory_sync: RTL
=====================

// Module: data_memory_sync
// PURPOSE
// - Clocked, parametrised data memory for the 8-bit processor datapath; successor to the combinational data RAM.
// - Single port, registered read with 1-cycle latency, read-over-write priority, address range checking.
// - A post-reset init sweep zeroes every word; the block reports busy until the sweep is done.
// - Sits between the load/store stage and the register file write-back.
// PARAMETERS
// - DATA_W     8   word width in bits
// - ADDR_W     8   address width in bits
// - DEPTH      36  number of words; legal addresses 0..DEPTH-1; must satisfy DEPTH <= 2**ADDR_W (elaboration error otherwise)
// - INIT_ZERO  1   1: zero-fill sweep after reset; 0: skip the sweep, memory contents undefined
// PORTS
// - clk      in   1       clock; all state updates on the rising edge
// - rst      in   1       reset, asynchronous, active-high
// - rd_en    in   1       read request, sampled at the clock edge
// - wr_en    in   1       write request, sampled at the clock edge
// - addr     in   ADDR_W  word address for a read or a write
// - wr_data  in   DATA_W  write data
// - rd_data  out  DATA_W  registered read data
// - rd_valid out  1       1-cycle pulse: rd_data holds a fresh read result
// - addr_err out  1       1-cycle pulse: the previous accepted request had addr >= DEPTH
// - busy     out  1       1 during reset and the init sweep; requests are ignored while it is 1
// BEHAVIOUR
// - Clock and reset: one clock (clk); rst is asynchronous and active-high.
// - Reset values (async): state=INIT (IDLE if INIT_ZERO=0), init_cnt=0, rd_data=0, rd_valid=0, addr_err=0.
//   busy=1 while rst is high.
// - The RAM array itself is not reset.
// - FSM, two states:
//   - INIT: each cycle writes 0 to mem[init_cnt] and increments init_cnt; after writing DEPTH-1, go to IDLE. busy=1.
//   - IDLE: busy=0; requests are accepted.
//   - Sweep length: exactly DEPTH cycles after rst deasserts.
//   - rst asserted mid-sweep: sweep restarts from address 0.
// - Accept rule: a request is accepted when busy=0 and (rd_en | wr_en) at the clock edge.
//   - Requests presented while busy=1 are dropped silently: no write, no rd_valid, no addr_err.
// - Read, rd_en=1 with addr < DEPTH:
//   - rd_data <= mem[addr] at the accepting edge; rd_valid=1 for the next cycle only.
//   - rd_data holds its value until the next accepted read.
// - Write, wr_en=1 and rd_en=0 with addr < DEPTH: mem[addr] <= wr_data at the edge. rd_valid stays 0; rd_data unchanged.
// - rd_en=1 and wr_en=1 together: the read is performed and the write is discarded (legacy Rm priority).
// - Out of range, addr >= DEPTH:
//   - Write is dropped.
//   - Read returns rd_data=0 with rd_valid=1.
//   - addr_err=1 for one cycle, aligned with where rd_valid would be.
// - Read after write: a read of address A in the cycle after a write to A returns the new data.
// - Back-to-back reads: one result per cycle; rd_valid stays high continuously.
// - Widths: no arithmetic on data. Address compare is unsigned against DEPTH, zero-extended to ADDR_W+1 bits.
// STRUCTURE
// - Package dmem_pkg holds:
//   - typedef enum logic {DM_INIT, DM_IDLE} dm_state_t;
//   - localparam DM_DATA_W_DEF=8, DM_ADDR_W_DEF=8, DM_DEPTH_DEF=36.
// - Sub-module dm_ram_core (DATA_W, DEPTH): plain sync single-port array with we, waddr, wdata, raddr, rdata.
//   - Inferable as a block or distributed RAM.
// - The top level owns the FSM, init counter, range check, write mux (init sweep vs. user write) and output registers.
// TESTING
// - Reset, then count busy cycles:
//   - rst 1 -> 0 with DEPTH=36: busy=1 for exactly 36 cycles, then 0.
//   - Reading addr 0..35 afterwards returns 0x00 each, with rd_valid pulses.
// - Write then read:
//   - wr_en addr=5 data=0xA7, next cycle rd_en addr=5 -> next cycle rd_data=0xA7, rd_valid=1, addr_err=0.
// - Simultaneous request:
//   - mem[3]=0x11; rd_en=wr_en=1 addr=3 data=0x22 -> rd_data=0x11.
//   - A later read of addr 3 still returns 0x11.
// - Out of range:
//   - wr_en addr=36 data=0xFF -> addr_err pulse, no write.
//   - rd_en addr=200 -> rd_data=0x00, rd_valid=1, addr_err=1 for one cycle.
// - Busy drop:
//   - During the sweep, wr_en addr=2 data=0x55 -> ignored.
//   - After the sweep, reading addr 2 returns 0x00; no rd_valid or addr_err pulse occurred during busy.
// - Reset mid-operation:
//   - Assert rst at sweep cycle 10 -> outputs go to reset values at once.
//   - After release, busy lasts the full 36 cycles again.
//   - Also check: rst during a read clears rd_valid immediately.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the clocked data memory.
package dmem_pkg;

  typedef enum logic {DM_INIT, DM_IDLE} dm_state_t;

  localparam int DM_DATA_W_DEF = 8;
  localparam int DM_ADDR_W_DEF = 8;
  localparam int DM_DEPTH_DEF  = 36;

endpackage

// File: rtl/dm_ram_core.sv
// Single-port word array: synchronous write, combinational read.
// The top owns the output register, so this infers as distributed RAM.
module dm_ram_core #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 36,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Out-of-range raddr values are masked by the caller.
  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_sync.sv
// Clocked data memory: zero-fill sweep after reset, registered read,
// read-over-write priority and address range checking.
module data_memory_sync
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DM_DATA_W_DEF,
  parameter int ADDR_W    = DM_ADDR_W_DEF,
  parameter int DEPTH     = DM_DEPTH_DEF,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam dm_state_t RST_STATE = (INIT_ZERO != 0) ? DM_INIT : DM_IDLE;

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
    $error("data_memory_sync: DEPTH must be in 1..2**ADDR_W");
  end

  dm_state_t         state_q, state_d;
  logic [AW-1:0]     init_cnt_q, init_cnt_d;
  logic              in_range, acc, acc_rd;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Unsigned compare with one spare bit so DEPTH == 2**ADDR_W still fits.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign busy     = rst | (state_q == DM_INIT);
  assign acc      = !busy & (rd_en | wr_en);
  assign acc_rd   = acc & rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_we     = acc & wr_en & !rd_en & in_range;
    ram_waddr  = addr[AW-1:0];
    ram_wdata  = wr_data;
    case (state_q)
      DM_INIT: begin
        // Sweep owns the write port; user requests are dropped while busy.
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == LAST) begin
          state_d    = DM_IDLE;
          init_cnt_d = '0;
        end
      end
      default: state_d = DM_IDLE;
    endcase
  end

  dm_ram_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(addr[AW-1:0]),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= acc_rd;
      addr_err <= acc & !in_range;
      if (acc_rd) rd_data <= in_range ? ram_rdata : '0;
    end
  end

endmodule
